ssp_boot_loader: RTL
====================

// Module: ssp_boot_loader
// PURPOSE
//  Upstream init/boot stage for superscaler_processor. It holds the core in reset, clears the register file,
//  fills instruction memory with NOP words, then streams a program image into MEM over a valid/ready port.
//  It releases the core only after the image is written. This replaces hierarchical REG/MEM preloading with
//  synthesizable write ports.
// PARAMETERS
//  NUM_REGS   32            registers cleared (reg_waddr width = $clog2(NUM_REGS))
//  REG_W      32            register data width
//  MEM_DEPTH  1024          instruction words in MEM
//  ADDR_W     10            MEM address width, >= $clog2(MEM_DEPTH)
//  NOP_WORD   32'hFC000000  fill word, {NOP=6'b111111,26'd0}
// PORTS
//  clk1       in   1          single clock; all logic on posedge clk1
//  reset      in   1          synchronous, active-high
//  start      in   1          1-cycle request; honoured in IDLE and RUN only
//  ld_valid   in   1          program word valid
//  ld_ready   out  1          loader accepts word (LOAD state only)
//  ld_data    in   32         instruction word
//  ld_last    in   1          marks final word of image
//  reg_we     out  1          register-file write strobe
//  reg_waddr  out  5          register index
//  reg_wdata  out  REG_W      always 0
//  mem_we     out  1          MEM write strobe
//  mem_waddr  out  ADDR_W     MEM word address
//  mem_wdata  out  32         MEM write data
//  cpu_reset  out  1          reset to processor core; 1 in every state except RUN
//  busy       out  1          1 in CLR_REG/CLR_MEM/LOAD/FLUSH
//  done       out  1          1 in RUN
//  load_count out  ADDR_W+1   words accepted in current load
//  overflow   out  1          sticky: image filled MEM without ld_last
// BEHAVIOUR
//  Reset: state=IDLE; cpu_reset=1; all strobes, ld_ready, busy, done, overflow, load_count and addresses = 0.
//   Reset mid-operation aborts at that edge; no further writes; no partial-state resume.
//  All outputs are registered. Write strobes fire in the cycle after the edge that generated them.
//  FSM:
//   IDLE    -> CLR_REG on start. ld_valid ignored.
//   CLR_REG reg_we=1; addr 0..NUM_REGS-1, one per cycle; -> CLR_MEM after addr NUM_REGS-1.
//   CLR_MEM mem_we=1, mem_wdata=NOP_WORD; addr 0..MEM_DEPTH-1; -> LOAD after last addr.
//           On LOAD entry: ptr=0, load_count=0, overflow=0.
//   LOAD    ld_ready=1. On each edge with ld_valid&ld_ready: write ld_data at ptr; ptr++; load_count++.
//           Gaps in ld_valid stall without writes. -> FLUSH on the edge accepting ld_last.
//           -> FLUSH on the edge accepting the word at ptr=MEM_DEPTH-1; set overflow if ld_last=0.
//           ld_ready is 0 from the FLUSH cycle on; no word is accepted past MEM_DEPTH-1.
//   FLUSH   one cycle; final mem_we visible; ld_ready=0; cpu_reset=1. -> RUN.
//   RUN     cpu_reset=0, done=1, all strobes 0. start -> CLR_REG; cpu_reset=1 again from next cycle.
//  start in CLR_REG/CLR_MEM/LOAD/FLUSH is ignored.
//  Never reg_we and mem_we in the same cycle. Addresses hold last value when strobes are low.
//  Latency start->first load ready = NUM_REGS+MEM_DEPTH+1 cycles (1057 at defaults).
//  Last accepted word -> cpu_reset low = 2 edges.
// TESTING
//  1 Reset 3 cycles, then idle 10 cycles -> cpu_reset=1, no strobes, ld_ready=0, done=0.
//  2 start pulse at defaults -> 32 reg_we (addr 0..31, data 0), then 1024 mem_we of 32'hFC000000,
//    contiguous; ld_ready rises exactly 1057 cycles after start.
//  3 Load 3 words 32'h20220005, 32'h20430003, 32'h00411800 (last on 3rd), ld_valid gap of 2 cycles
//    between words 1 and 2 -> MEM[0..2] written in order; load_count=3; overflow=0;
//    done=1 and cpu_reset=0 two edges after 3rd accept.
//  4 MEM_DEPTH=8, 8 words, no ld_last -> 8 writes only; overflow=1; ld_ready=0 after 8th accept;
//    9th offered word never accepted; RUN reached.
//  5 reset asserted during CLR_MEM at addr 100 -> strobes 0 from next cycle; IDLE; cpu_reset=1;
//    re-start repeats the full clear from reg addr 0.
//  6 start in RUN -> cpu_reset=1 next cycle; full clear/load re-executes; overflow and load_count reset on LOAD entry.

Source files
------------

// File: rtl/ssp_boot_loader.sv
// ============================================================================
// Module      : ssp_boot_loader
// Description : Boot stage for superscaler_processor. Holds the core in reset,
//               clears the register file, fills MEM with NOP words, streams a
//               program image in over valid/ready, then releases the core.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module ssp_boot_loader #(
    parameter int          NUM_REGS  = 32,
    parameter int          REG_W     = 32,
    parameter int          MEM_DEPTH = 1024,
    parameter int          ADDR_W    = 10,
    parameter logic [31:0] NOP_WORD  = 32'hFC000000,
    localparam int         RA_W      = $clog2(NUM_REGS)
) (
    input  logic              clk1,
    input  logic              reset,
    input  logic              start,
    input  logic              ld_valid,
    output logic              ld_ready,
    input  logic [31:0]       ld_data,
    input  logic              ld_last,
    output logic              reg_we,
    output logic [RA_W-1:0]   reg_waddr,
    output logic [REG_W-1:0]  reg_wdata,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_waddr,
    output logic [31:0]       mem_wdata,
    output logic              cpu_reset,
    output logic              busy,
    output logic              done,
    output logic [ADDR_W:0]   load_count,
    output logic              overflow
);

    localparam logic [RA_W-1:0]   REG_LAST = RA_W'(NUM_REGS - 1);
    localparam logic [ADDR_W-1:0] MEM_LAST = ADDR_W'(MEM_DEPTH - 1);

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_CLR_REG = 3'd1,
        S_CLR_MEM = 3'd2,
        S_LOAD    = 3'd3,
        S_FLUSH   = 3'd4,
        S_RUN     = 3'd5
    } state_t;

    state_t              state_q;
    logic                ld_ready_q;
    logic                reg_we_q;
    logic [RA_W-1:0]     reg_waddr_q;
    logic                mem_we_q;
    logic [ADDR_W-1:0]   mem_waddr_q;
    logic [31:0]         mem_wdata_q;
    logic                cpu_reset_q;
    logic                busy_q;
    logic                done_q;
    logic [ADDR_W:0]     load_count_q;
    logic                overflow_q;
    logic [ADDR_W-1:0]   ptr_q;

    // Every output is a register; each transition sets the outputs for the
    // state being entered, so strobes appear in the cycle after their edge.
    always_ff @(posedge clk1) begin
        if (reset) begin
            state_q      <= S_IDLE;
            ld_ready_q   <= 1'b0;
            reg_we_q     <= 1'b0;
            reg_waddr_q  <= '0;
            mem_we_q     <= 1'b0;
            mem_waddr_q  <= '0;
            mem_wdata_q  <= '0;
            cpu_reset_q  <= 1'b1;
            busy_q       <= 1'b0;
            done_q       <= 1'b0;
            load_count_q <= '0;
            overflow_q   <= 1'b0;
            ptr_q        <= '0;
        end else begin
            reg_we_q <= 1'b0;
            mem_we_q <= 1'b0;
            case (state_q)
                S_IDLE: begin
                    if (start) begin
                        state_q     <= S_CLR_REG;
                        reg_we_q    <= 1'b1;
                        reg_waddr_q <= '0;
                        busy_q      <= 1'b1;
                    end
                end
                S_CLR_REG: begin
                    if (reg_waddr_q == REG_LAST) begin
                        state_q     <= S_CLR_MEM;
                        mem_we_q    <= 1'b1;
                        mem_waddr_q <= '0;
                        mem_wdata_q <= NOP_WORD;
                    end else begin
                        reg_we_q    <= 1'b1;
                        reg_waddr_q <= reg_waddr_q + 1'b1;
                    end
                end
                S_CLR_MEM: begin
                    if (mem_waddr_q == MEM_LAST) begin
                        state_q      <= S_LOAD;
                        ld_ready_q   <= 1'b1;
                        ptr_q        <= '0;
                        load_count_q <= '0;
                        overflow_q   <= 1'b0;
                    end else begin
                        mem_we_q    <= 1'b1;
                        mem_waddr_q <= mem_waddr_q + 1'b1;
                    end
                end
                S_LOAD: begin
                    if (ld_valid && ld_ready_q) begin
                        mem_we_q     <= 1'b1;
                        mem_waddr_q  <= ptr_q;
                        mem_wdata_q  <= ld_data;
                        ptr_q        <= ptr_q + 1'b1;
                        load_count_q <= load_count_q + 1'b1;
                        // A full MEM ends the load even without ld_last.
                        if (ld_last || (ptr_q == MEM_LAST)) begin
                            state_q    <= S_FLUSH;
                            ld_ready_q <= 1'b0;
                            overflow_q <= ~ld_last;
                        end
                    end
                end
                S_FLUSH: begin
                    state_q     <= S_RUN;
                    busy_q      <= 1'b0;
                    done_q      <= 1'b1;
                    cpu_reset_q <= 1'b0;
                end
                S_RUN: begin
                    if (start) begin
                        state_q     <= S_CLR_REG;
                        reg_we_q    <= 1'b1;
                        reg_waddr_q <= '0;
                        busy_q      <= 1'b1;
                        done_q      <= 1'b0;
                        cpu_reset_q <= 1'b1;
                    end
                end
                default: begin
                    state_q     <= S_IDLE;
                    ld_ready_q  <= 1'b0;
                    busy_q      <= 1'b0;
                    done_q      <= 1'b0;
                    cpu_reset_q <= 1'b1;
                end
            endcase
        end
    end

    assign ld_ready   = ld_ready_q;
    assign reg_we     = reg_we_q;
    assign reg_waddr  = reg_waddr_q;
    assign reg_wdata  = '0;
    assign mem_we     = mem_we_q;
    assign mem_waddr  = mem_waddr_q;
    assign mem_wdata  = mem_wdata_q;
    assign cpu_reset  = cpu_reset_q;
    assign busy       = busy_q;
    assign done       = done_q;
    assign load_count = load_count_q;
    assign overflow   = overflow_q;

endmodule

`default_nettype wire
